alu_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares the single combinational 32-bit ALU between two requesters, e.g. the execute stage and a multiply/divide helper. It accepts one operation at a time over a valid/ready handshake, registers operands, drives the ALU, screens illegal operations, and returns the registered result and zero flag to the winning port. It sits between the requesters and the ALU instance; the ALU instance is outside this block.

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one combinational ALU between two requesters.
// It accepts one op at a time, screens illegal opcodes and returns a registered result to the winner.
module alu_arbiter #(
    parameter int unsigned W  = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [W-1:0]  req_a0,
    input  logic [W-1:0]  req_b0,
    input  logic [W-1:0]  req_a1,
    input  logic [W-1:0]  req_b1,
    input  logic [3:0]    req_sel0,
    input  logic [3:0]    req_sel1,
    output logic [1:0]    resp_valid,
    input  logic [1:0]    resp_ready,
    output logic [W-1:0]  resp_res,
    output logic          resp_zf,
    output logic          resp_err,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_sel,
    input  logic [W-1:0]  alu_res,
    input  logic          alu_zf,
    output logic [CW-1:0] done_cnt0,
    output logic [CW-1:0] done_cnt1
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] SEL_ZERO = 4'b1101;
    localparam logic [3:0] SEL_DIV  = 4'b1000;

    logic [1:0]    state_q, state_d;
    logic          rr_q, rr_d;
    logic          port_q, port_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [3:0]    sel_q, sel_d;
    logic [W-1:0]  res_q, res_d;
    logic          zf_q, zf_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    logic grant;
    logic illegal;

    // Single valid port wins outright; a tie goes to the round-robin pointer.
    assign grant = (req_valid == 2'b11) ? rr_q : req_valid[1];

    always_comb begin
        req_ready = 2'b00;
        if (state_q == S_IDLE && req_valid != 2'b00) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    assign illegal = (sel_q == 4'b0011) || (sel_q == 4'b1100) || (sel_q == 4'b1111) ||
                     ((sel_q == SEL_DIV) && (b_q == '0));

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        port_d  = port_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        res_d   = res_q;
        zf_d    = zf_q;
        err_d   = err_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        case (state_q)
            S_IDLE: begin
                if ((req_valid & req_ready) != 2'b00) begin
                    port_d  = grant;
                    rr_d    = ~grant;
                    a_d     = grant ? req_a1 : req_a0;
                    b_d     = grant ? req_b1 : req_b0;
                    sel_d   = grant ? req_sel1 : req_sel0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = illegal ? '0 : alu_res;
                zf_d    = illegal ? 1'b0 : alu_zf;
                err_d   = illegal;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready[port_q]) begin
                    if (port_q) cnt1_d = cnt1_q + CW'(1);
                    else        cnt0_d = cnt0_q + CW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            port_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 4'b0000;
            res_q   <= '0;
            zf_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            port_q  <= port_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
            err_q   <= err_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    // ALU sees the held operands only while executing; otherwise a quiet constant-zero op.
    assign alu_a   = (state_q == S_EXEC) ? a_q : '0;
    assign alu_b   = (state_q == S_EXEC) ? b_q : '0;
    assign alu_sel = (state_q == S_EXEC) ? sel_q : SEL_ZERO;

    assign resp_valid = (state_q == S_RESP) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_res   = res_q;
    assign resp_zf    = zf_q;
    assign resp_err   = err_q;
    assign done_cnt0  = cnt0_q;
    assign done_cnt1  = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU stub; a CW=4 twin checks counter wrap.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  resp_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  sel0, sel1;
    logic [31:0] alu_res;
    logic        alu_zf;

    logic [1:0]  req_ready, resp_valid;
    logic [31:0] resp_res, alu_a, alu_b;
    logic        resp_zf, resp_err;
    logic [3:0]  alu_sel;
    logic [15:0] cnt0, cnt1;

    logic [1:0]  s_req_ready, s_resp_valid;
    logic [31:0] s_resp_res, s_alu_a, s_alu_b;
    logic        s_resp_zf, s_resp_err;
    logic [3:0]  s_alu_sel;
    logic [3:0]  s_cnt0, s_cnt1;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.W(32), .CW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .req_sel0(sel0), .req_sel1(sel1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_res(resp_res), .resp_zf(resp_zf), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_res(alu_res), .alu_zf(alu_zf),
        .done_cnt0(cnt0), .done_cnt1(cnt1)
    );

    alu_arbiter #(.W(32), .CW(4)) dut_s (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .req_sel0(sel0), .req_sel1(sel1),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready),
        .resp_res(s_resp_res), .resp_zf(s_resp_zf), .resp_err(s_resp_err),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_sel(s_alu_sel),
        .alu_res(alu_res), .alu_zf(alu_zf),
        .done_cnt0(s_cnt0), .done_cnt1(s_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub; divide-by-zero returns a loud nonzero value with zf set so leakage shows.
    always_comb begin
        alu_zf = 1'b0;
        case (alu_sel)
            4'b0000: alu_res = alu_a & alu_b;
            4'b0001: alu_res = alu_a | alu_b;
            4'b0010: alu_res = alu_a + alu_b;
            4'b0110: alu_res = alu_a - alu_b;
            4'b0111: alu_res = alu_a ^ alu_b;
            4'b1000: alu_res = (alu_b == 0) ? 32'hDEAD_BEEF : alu_a / alu_b;
            4'b1101: alu_res = 32'h0;
            default: alu_res = (alu_a ^ alu_b) + 32'h1;
        endcase
        alu_zf = (alu_res == 32'h0) || (alu_sel == 4'b1000 && alu_b == 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; sel0 = 0; sel1 = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got=%b exp=00", resp_valid); end
        checks++; if (resp_res !== 32'h0 || resp_zf !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp got=%h/%b/%b exp=0/0/0", resp_res, resp_zf, resp_err); end
        checks++; if (cnt0 !== 16'h0 || cnt1 !== 16'h0) begin errors++; $display("FAIL rst_cnt got=%h/%h exp=0/0", cnt0, cnt1); end
        checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_sel !== 4'b1101) begin errors++; $display("FAIL rst_alu got=%h/%h/%b exp=0/0/1101", alu_a, alu_b, alu_sel); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
    endtask

    task automatic test_basic();
        req_valid = 2'b01; a0 = 5; b0 = 3; sel0 = 4'b0010; resp_ready = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL basic_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_sel !== 4'b0010) begin errors++; $display("FAIL basic_alu got=%h/%h/%b exp=5/3/0010", alu_a, alu_b, alu_sel); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL basic_exec_valid got=%b exp=00", resp_valid); end
        tick();
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL basic_valid got=%b exp=01", resp_valid); end
        checks++; if (resp_res !== 32'd8 || resp_zf !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL basic_resp got=%h/%b/%b exp=8/0/0", resp_res, resp_zf, resp_err); end
        tick();
        checks++; if (resp_valid !== 2'b00 || cnt0 !== 16'd1) begin errors++; $display("FAIL basic_done got=%b/%0d exp=00/1", resp_valid, cnt0); end
    endtask

    task automatic test_round_robin();
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 2'b11; a0 = 7; b0 = 7; a1 = 7; b1 = 7; sel0 = 4'b0110; sel1 = 4'b0110; resp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp_g;
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, exp_g); end
            tick();
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_exec_ready%0d got=%b exp=00", i, req_ready); end
            tick();
            checks++; if (resp_valid !== exp_g || resp_res !== 32'h0 || resp_zf !== 1'b1) begin errors++; $display("FAIL rr_resp%0d got=%b/%h/%b exp=%b/0/1", i, resp_valid, resp_res, resp_zf, exp_g); end
            tick();
        end
        req_valid = 2'b00;
        checks++; if (cnt0 !== 16'd2 || cnt1 !== 16'd2) begin errors++; $display("FAIL rr_cnt got=%0d/%0d exp=2/2", cnt0, cnt1); end
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            req_valid = 2'b10; a1 = 9; b1 = 0; sel1 = (k == 0) ? 4'b1000 : 4'b1100;
            #1;
            checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL ill_ready%0d got=%b exp=10", k, req_ready); end
            tick();
            req_valid = 2'b00;
            checks++; if (alu_a !== 32'd9 || alu_sel !== sel1) begin errors++; $display("FAIL ill_alu%0d got=%h/%b exp=9/%b", k, alu_a, alu_sel, sel1); end
            tick();
            checks++; if (resp_valid !== 2'b10 || resp_err !== 1'b1 || resp_res !== 32'h0 || resp_zf !== 1'b0) begin errors++; $display("FAIL ill_resp%0d got=%b/%b/%h/%b exp=10/1/0/0", k, resp_valid, resp_err, resp_res, resp_zf); end
            tick();
        end
        checks++; if (cnt1 !== 16'd4) begin errors++; $display("FAIL ill_cnt got=%0d exp=4", cnt1); end
    endtask

    task automatic test_backpressure();
        resp_ready = 2'b00; req_valid = 2'b11;
        a0 = 6; b0 = 3; sel0 = 4'b0111; a1 = 1; b1 = 1; sel1 = 4'b0010;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_grant got=%b exp=01", req_ready); end
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 2'b01 || resp_res !== 32'd5 || resp_err !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL bp_hold%0d got=%b/%h/%b/%b exp=01/5/0/00", i, resp_valid, resp_res, resp_err, req_ready); end
            resp_ready = 2'b10;
            tick();
        end
        resp_ready = 2'b01;
        tick();
        checks++; if (resp_valid !== 2'b00 || cnt0 !== 16'd3) begin errors++; $display("FAIL bp_done got=%b/%0d exp=00/3", resp_valid, cnt0); end
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next got=%b exp=10", req_ready); end
        resp_ready = 2'b11;
        tick();
        req_valid = 2'b00;
        tick();
        checks++; if (resp_valid !== 2'b10 || resp_res !== 32'd2) begin errors++; $display("FAIL bp_p1 got=%b/%h exp=10/2", resp_valid, resp_res); end
        tick();
        checks++; if (cnt1 !== 16'd5) begin errors++; $display("FAIL bp_cnt1 got=%0d exp=5", cnt1); end
    endtask

    task automatic test_reset_abort();
        resp_ready = 2'b11; req_valid = 2'b01; a0 = 1; b0 = 2; sel0 = 4'b0010;
        tick();
        req_valid = 2'b00; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (resp_valid !== 2'b00 || cnt0 !== 16'h0 || cnt1 !== 16'h0 || alu_sel !== 4'b1101) begin errors++; $display("FAIL abort_exec got=%b/%0d/%0d/%b exp=00/0/0/1101", resp_valid, cnt0, cnt1, alu_sel); end
        tick();
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL abort_exec_late got=%b exp=00", resp_valid); end
        resp_ready = 2'b00; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        checks++; if (resp_valid !== 2'b01 || resp_res !== 32'd3) begin errors++; $display("FAIL abort_pre got=%b/%h exp=01/3", resp_valid, resp_res); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (resp_valid !== 2'b00 || resp_res !== 32'h0 || resp_err !== 1'b0 || cnt0 !== 16'h0) begin errors++; $display("FAIL abort_resp got=%b/%h/%b/%0d exp=00/0/0/0", resp_valid, resp_res, resp_err, cnt0); end
        resp_ready = 2'b11;
    endtask

    task automatic test_back_to_back();
        req_valid = 2'b01; a0 = 4; b0 = 4; sel0 = 4'b0010; resp_ready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_ready%0d got=%b exp=01", k, req_ready); end
            tick();
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL b2b_exec%0d got=%b exp=00", k, req_ready); end
            tick();
            checks++; if (req_ready !== 2'b00 || resp_valid !== 2'b01 || resp_res !== 32'd8) begin errors++; $display("FAIL b2b_resp%0d got=%b/%b/%h exp=00/01/8", k, req_ready, resp_valid, resp_res); end
            tick();
        end
        req_valid = 2'b00;
        checks++; if (cnt0 !== 16'd2) begin errors++; $display("FAIL b2b_cnt got=%0d exp=2", cnt0); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 2'b10; resp_ready = 2'b10; a1 = 1; b1 = 2; sel1 = 4'b0010;
        for (int i = 0; i < 15; i++) begin
            tick(); tick(); tick();
        end
        checks++; if (s_cnt1 !== 4'hF || cnt1 !== 16'd15) begin errors++; $display("FAIL wrap_pre got=%h/%0d exp=f/15", s_cnt1, cnt1); end
        tick(); tick(); tick();
        req_valid = 2'b00;
        checks++; if (s_cnt1 !== 4'h0 || cnt1 !== 16'd16) begin errors++; $display("FAIL wrap got=%h/%0d exp=0/16", s_cnt1, cnt1); end
        checks++; if (s_cnt0 !== 4'h0 || cnt0 !== 16'h0) begin errors++; $display("FAIL wrap_other got=%h/%0d exp=0/0", s_cnt0, cnt0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_illegal();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
